// File: rtl/mem_access_sequencer.sv
// Shares one single-ported word memory between instruction fetch and load/store,
// arbitrating round-robin and running byte/half stores as read-modify-write.
module mem_access_sequencer #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_size,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned HW = DW / 2;
  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_IF_RD, S_LD_RD, S_ST_WR, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t        state, state_d;
  logic          last_ls, last_ls_d;
  logic [1:0]    off_q, off_d;
  logic          half_q, half_d;
  logic [HW-1:0] wdata_q, wdata_d;

  logic          mem_req_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          if_done_d, ls_done_d, ls_misalign_d;
  logic [DW-1:0] if_rdata_d, ls_rdata_d;

  logic if_wins, ls_word, ls_half, ls_misal, acked;
  logic unused_ok;

  assign unused_ok = ^if_addr[1:0];
  assign if_wins   = if_req && (!ls_req || last_ls);
  assign ls_word   = !ls_size[1];
  assign ls_half   = (ls_size == 2'b11);
  assign ls_misal  = (ls_half && ls_addr[0]) || (ls_word && (ls_addr[1:0] != 2'b00));
  assign acked     = mem_req && mem_ack;

  // Replace the targeted byte or half lane of the read word with the store data.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] word, input logic [1:0] off,
                                          input logic half, input logic [HW-1:0] data);
    logic [DW-1:0] res;
    res = word;
    if (half) res[{off[1], 4'b0000} +: HW] = data;
    else      res[{off, 3'b000} +: BW]     = data[BW-1:0];
    return res;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    last_ls_d     = last_ls;
    off_d         = off_q;
    half_d        = half_q;
    wdata_d       = wdata_q;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    if_done_d     = 1'b0;
    if_rdata_d    = if_rdata;
    ls_done_d     = 1'b0;
    ls_rdata_d    = ls_rdata;
    ls_misalign_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (if_wins) begin
          last_ls_d   = 1'b0;
          state_d     = S_IF_RD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[AW-1:2], 2'b00};
          mem_wdata_d = '0;
        end else if (ls_req) begin
          last_ls_d  = 1'b1;
          off_d      = ls_addr[1:0];
          half_d     = ls_half;
          wdata_d    = ls_wdata[HW-1:0];
          mem_addr_d = {ls_addr[AW-1:2], 2'b00};
          if (ls_misal) begin
            state_d       = S_RESP;
            ls_done_d     = 1'b1;
            ls_misalign_d = 1'b1;
            ls_rdata_d    = '0;
          end else if (!ls_we) begin
            state_d     = S_LD_RD;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end else if (ls_word) begin
            state_d     = S_ST_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = ls_wdata;
          end else begin
            state_d     = S_RMW_RD;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end
      S_IF_RD: begin
        if (acked) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      S_LD_RD: begin
        if (acked) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = mem_rdata;
        end
      end
      S_ST_WR: begin
        if (acked) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = '0;
        end
      end
      S_RMW_RD: begin
        if (acked) begin
          state_d     = S_RMW_WR;
          mem_req_d   = 1'b0;
          mem_wdata_d = merge(mem_rdata, off_q, half_q, wdata_q);
        end
      end
      S_RMW_WR: begin
        // First cycle here is the idle hop after the read ack; the write request follows.
        if (!mem_req) begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end else if (mem_ack) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_ls     <= 1'b1;
      off_q       <= '0;
      half_q      <= 1'b0;
      wdata_q     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_done     <= 1'b0;
      if_rdata    <= '0;
      ls_done     <= 1'b0;
      ls_rdata    <= '0;
      ls_misalign <= 1'b0;
    end else begin
      state       <= state_d;
      last_ls     <= last_ls_d;
      off_q       <= off_d;
      half_q      <= half_d;
      wdata_q     <= wdata_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      if_done     <= if_done_d;
      if_rdata    <= if_rdata_d;
      ls_done     <= ls_done_d;
      ls_rdata    <= ls_rdata_d;
      ls_misalign <= ls_misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: memory responder with variable ack latency,
// reference memory model, directed corner cases followed by randomized concurrent traffic.
module tb_mem_access_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [1:0]    ls_size;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_done;
  logic [DW-1:0] ls_rdata;
  logic          ls_misalign;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  typedef struct { logic [31:0] rdata; logic mis; logic chk_data; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  wr_t  wr_q[$];
  int   lat_q[$];
  logic [31:0] mem_arr [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_lat = 0;
  int req_cycles = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  mem_access_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_misalign(ls_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    mem_arr[a >> 2] = v;
    ref_mem[a >> 2] = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: acks after a per-request wait, checks writes against expected stores.
  initial begin : responder
    bit busy;
    int wait_c;
    logic we_s;
    logic [31:0] addr_s, wd_s;
    wr_t e;
    busy = 0; wait_c = 0; we_s = 0; addr_s = 0; wd_s = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        busy = 0;
      end else begin
        req_cycles++;
        if (!busy) begin
          busy = 1;
          if (lat_q.size() != 0) wait_c = lat_q.pop_front();
          else if (ack_lat < 0)  wait_c = int'($urandom_range(0, 3));
          else                   wait_c = ack_lat;
          we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata;
          check("mem_addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
        end else begin
          check("mem_we_stable", 32'(mem_we), 32'(we_s));
          check("mem_addr_stable", mem_addr, addr_s);
          check("mem_wdata_stable", mem_wdata, wd_s);
        end
        if (wait_c == 0) begin
          mem_ack = 1'b1;
          busy = 0;
          last_addr = mem_addr;
          if (mem_we) begin
            last_wdata = mem_wdata;
            if (wr_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no store outstanding",
                       mem_addr, mem_wdata);
            end else begin
              e = wr_q.pop_front();
              check("wr_addr", mem_addr, e.addr);
              check("wr_data", mem_wdata, e.data);
            end
            mem_arr[mem_addr >> 2] = mem_wdata;
          end else begin
            mem_rdata = mem_rd(mem_addr);
          end
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Scoreboard monitor: pops the expected response whenever a done pulse appears.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done) begin
        if (if_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL if_done_unexpected: if_done=1 with no fetch outstanding");
        end else begin
          e = if_q.pop_front();
          check("if_rdata", if_rdata, e.rdata);
        end
      end
      if (ls_done) begin
        if (ls_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ls_done_unexpected: ls_done=1 with no load/store outstanding");
        end else begin
          e = ls_q.pop_front();
          check("ls_misalign", 32'(ls_misalign), 32'(e.mis));
          if (e.chk_data) check("ls_rdata", ls_rdata, e.rdata);
        end
      end else if (ls_misalign) begin
        tests++; fails++;
        $display("FAIL ls_misalign_alone: ls_misalign=1 while ls_done=0");
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int done_cyc);
    exp_t e;
    int n;
    e.rdata = ref_rd(a); e.mis = 1'b0; e.chk_data = 1'b1;
    if_q.push_back(e);
    if_addr = a; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 100);
    if (!if_done) begin
      tests++; fails++;
      $display("FAIL fetch_timeout: no if_done within %0d cycles, addr 0x%08h", n, a);
    end
    done_cyc = cyc;
    if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int done_cyc);
    exp_t e;
    wr_t w;
    logic [31:0] old, mask, nw;
    int n, sh;
    logic mis;
    mis = ((sz == 2'b11) && (a % 2 != 0)) || ((sz == 2'b00 || sz == 2'b01) && (a % 4 != 0));
    old = ref_rd(a);
    e.mis = mis; e.chk_data = !mis; e.rdata = we ? 32'd0 : old;
    ls_q.push_back(e);
    if (!mis && we) begin
      if (sz == 2'b10) begin
        sh = 8 * int'(a % 4);
        mask = 32'hFF << sh;
        nw = (old & ~mask) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'b11) begin
        sh = 16 * int'((a % 4) / 2);
        mask = 32'hFFFF << sh;
        nw = (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end else begin
        nw = wd;
      end
      w.addr = a & ~32'h3; w.data = nw;
      wr_q.push_back(w);
      ref_mem[a >> 2] = nw;
    end
    ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_done && n < 100);
    if (!ls_done) begin
      tests++; fails++;
      $display("FAIL ls_timeout: no ls_done within %0d cycles, addr 0x%08h", n, a);
    end
    done_cyc = cyc;
    ls_req = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0, t1, rc, n, l1, l2;
    int ic[3];
    int lc[3];
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_ls_misalign", 32'(ls_misalign), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Both requesters held busy from reset: fetch first, then strict alternation.
    ack_lat = 0;
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 3; i++) do_fetch(32'h1100 + 32'(4 * i), ic[i]);
      for (int i = 0; i < 3; i++) do_ls(1'b0, 2'b00, 32'h8000 + 32'(4 * i), 32'd0, lc[i]);
    join
    for (int i = 0; i < 3; i++) begin
      check("rr_if_before_ls", 32'(ic[i] < lc[i]), 32'd1);
      if (i < 2) check("rr_ls_before_next_if", 32'(lc[i] < ic[i + 1]), 32'd1);
    end

    // Single fetch with zero-wait ack.
    @(posedge clk); #1; t0 = cyc;
    do_fetch(32'h100, t1);
    check("fetch_latency", 32'(t1 - t0), 32'd2);
    check("fetch_mem_addr", last_addr, 32'h100);

    // Byte store read-modify-write.
    preset(32'h200, 32'h11223344);
    @(posedge clk); #1; t0 = cyc;
    do_ls(1'b1, 2'b10, 32'h203, 32'h000000AB, t1);
    check("sb_latency", 32'(t1 - t0), 32'd4);
    check("sb_wdata", last_wdata, 32'hAB223344);
    check("sb_addr", last_addr, 32'h200);

    // Half store, then misaligned half store that must not touch memory.
    preset(32'h200, 32'h11223344);
    @(posedge clk); #1; t0 = cyc;
    do_ls(1'b1, 2'b11, 32'h202, 32'h0000BEEF, t1);
    check("sh_latency", 32'(t1 - t0), 32'd4);
    check("sh_wdata", last_wdata, 32'hBEEF3344);
    rc = req_cycles;
    @(posedge clk); #1; t0 = cyc;
    do_ls(1'b1, 2'b11, 32'h201, 32'h00001234, t1);
    check("sh_misal_latency", 32'(t1 - t0), 32'd1);
    check("sh_misal_no_mem_req", 32'(req_cycles - rc), 32'd0);
    rc = req_cycles;
    do_ls(1'b0, 2'b00, 32'h8002, 32'd0, t1);
    check("lw_misal_no_mem_req", 32'(req_cycles - rc), 32'd0);

    // Word store with a slow memory: outputs held stable, done one cycle after ack.
    ack_lat = 5;
    @(posedge clk); #1; t0 = cyc;
    do_ls(1'b1, 2'b00, 32'h8040, 32'hCAFEF00D, t1);
    check("sw_slow_latency", 32'(t1 - t0), 32'd7);
    check("sw_slow_wdata", last_wdata, 32'hCAFEF00D);

    // Reset while the RMW write phase is waiting for ack.
    ack_lat = 0;
    lat_q.push_back(0);
    lat_q.push_back(1000);
    @(posedge clk); #1;
    ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h8011; ls_wdata = 32'h5A; ls_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(mem_req && mem_we) && n < 50);
    check("rst_mid_reached_write", 32'(mem_req && mem_we), 32'd1);
    @(negedge clk);
    reset = 1'b1; ls_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_mem_req_dropped", 32'(mem_req), 32'd0);
    check("rst_mid_no_ls_done", 32'(ls_done), 32'd0);
    lat_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_quiet_ls_done", 32'(ls_done), 32'd0);
      check("rst_mid_quiet_mem_req", 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1; t0 = cyc;
    do_fetch(32'h180, t1);
    check("rst_mid_idle_after", 32'(t1 - t0), 32'd2);

    // Randomized concurrent traffic with random ack latency.
    ack_lat = -1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_fetch(32'h1000 + $urandom_range(0, 4095), l1);
        end
      end
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'h8000 + $urandom_range(0, 63), $urandom, l2);
        end
      end
    join
    // Read back every word of the store region through the DUT.
    for (int i = 0; i < 16; i++) do_ls(1'b0, 2'b00, 32'h8000 + 32'(4 * i), 32'd0, l2);

    repeat (5) @(negedge clk);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
